// File: rtl/sig_readback_pkg.sv
// Shared types and default sizing for the signature readback block.
package sig_readback_pkg;

  localparam int DEPTH_DEF = 100000;
  localparam int AW_DEF    = 17;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/sig_rd_addr.sv
// Readback address counter: clear, increment, and terminal-count flag at DEPTH-1.
module sig_rd_addr
  import sig_readback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          incr,
  output logic [AW-1:0] addr,
  output logic          last
);

  assign last = (addr == AW'(DEPTH - 1));

  // The last-address guard keeps the counter inside the RAM even if incr misfires.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (incr && !last) begin
      addr <= addr + AW'(1);
    end
  end

endmodule

// File: rtl/sig_readback.sv
// Streams DEPTH signature bits from a 1-cycle-latency RAM to a ready/valid consumer.
// Optional SIG_READBACK_ONES_CNT_EN adds a count of transferred one bits.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | ram_rden asserted for the current address
// WAIT  | RAM data returning, captured into out_bit
// HOLD  | out_valid high until the consumer takes the bit
// DONE  | one-cycle done pulse, address rewinds to 0
module sig_readback
  import sig_readback_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rden,
  input  logic          ram_q,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
`ifdef SIG_READBACK_ONES_CNT_EN
  ,
  output logic [AW-1:0] ones_cnt
`endif
);

  state_t state, state_nxt;
  logic   addr_clr;
  logic   addr_inc;
  logic   addr_last;
  logic   load_bit;

  sig_rd_addr #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .clear(addr_clr),
    .incr (addr_inc),
    .addr (ram_addr),
    .last (addr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_clr  = 1'b0;
    addr_inc  = 1'b0;
    load_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          addr_clr  = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        state_nxt = HOLD;
        load_bit  = 1'b1;
      end
      HOLD: begin
        if (out_ready) begin
          if (addr_last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            addr_inc  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        addr_clr  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort dominates every transition, including a start seen in IDLE.
    if (abort) begin
      state_nxt = IDLE;
      addr_clr  = 1'b1;
      addr_inc  = 1'b0;
      load_bit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_bit <= 1'b0;
    end else if (load_bit) begin
      out_bit <= ram_q;
    end
  end

  assign ram_rden  = (state == ISSUE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  // An abort landing on the DONE cycle suppresses the pulse.
  assign done      = (state == DONE) && !abort;

`ifdef SIG_READBACK_ONES_CNT_EN
  logic xfer;
  assign xfer = (state == HOLD) && out_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      ones_cnt <= '0;
    end else if (xfer && out_bit) begin
      ones_cnt <= ones_cnt + AW'(1);
    end
  end
`else
  // Default build carries no ones counter.
`endif

endmodule

// File: tb/tb_sig_readback.sv
// Directed bench for sig_readback with an 8-word signature RAM (10110010).
module tb_sig_readback;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] ram_addr;
  logic          ram_rden;
  logic          ram_q = 1'b0;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
`ifdef SIG_READBACK_ONES_CNT_EN
  logic [AW-1:0] ones_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic mem [0:DEPTH-1];

  sig_readback #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ram_addr (ram_addr),
    .ram_rden (ram_rden),
    .ram_q    (ram_q),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
`ifdef SIG_READBACK_ONES_CNT_EN
    ,
    .ones_cnt (ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Signature RAM model: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_rden) ram_q <= mem[ram_addr[2:0]];
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (ram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
    n_checks++; if (ram_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %b want 0", ram_rden); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_bit: got %b want 0", out_bit); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_pass();
    int k = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1, bit_err = 0, max_addr = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_rden) rd_cnt++;
      if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      if (out_valid && out_ready) begin
        if (k >= DEPTH || out_bit !== mem[k]) bit_err++;
        k++;
      end
      if (done) begin done_cnt++; done_cyc = c; end
    end
    n_checks++; if (bit_err != 0 || k != DEPTH) begin n_fail++; $display("FAIL pass_bits: got %0d bits with %0d errors want %0d bits 0 errors", k, bit_err, DEPTH); end
    n_checks++; if (rd_cnt != DEPTH) begin n_fail++; $display("FAIL pass_reads: got %0d want %0d", rd_cnt, DEPTH); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL pass_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc != 25) begin n_fail++; $display("FAIL pass_done_cycle: got %0d want 25", done_cyc); end
    n_checks++; if (max_addr != DEPTH - 1) begin n_fail++; $display("FAIL pass_max_addr: got %0d want %0d", max_addr, DEPTH - 1); end
    n_checks++; if (ram_addr !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL pass_end_state: got addr %0d busy %b want 0 0", ram_addr, busy); end
`ifdef SIG_READBACK_ONES_CNT_EN
    n_checks++; if (ones_cnt !== AW'(4)) begin n_fail++; $display("FAIL pass_ones_cnt: got %0d want 4", ones_cnt); end
`endif
  endtask

  task automatic test_stall();
    bit found = 0;
    int done_cnt = 0;
    bit saw_next = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) @(negedge clk);
      if (ram_addr == 3 && !ram_rden && !out_valid && busy) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach: got no WAIT at addr 3 want reached"); end
    out_ready = 1'b0;
    for (int h = 1; h <= 5; h++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_bit !== mem[3] || ram_addr !== AW'(3) || ram_rden !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got valid %b bit %b addr %0d rden %b want 1 %b 3 0", h, out_valid, out_bit, ram_addr, ram_rden, mem[3]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid && !saw_next) begin
        saw_next = 1;
        n_checks++; if (out_bit !== mem[4] || ram_addr !== AW'(4)) begin n_fail++; $display("FAIL stall_resume: got bit %b addr %0d want %b 4", out_bit, ram_addr, mem[4]); end
      end
      if (done) done_cnt++;
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    bit found = 0;
    int done_cnt = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) @(negedge clk);
      if (done) done_cnt++;
      if (ram_addr == 4 && !ram_rden && !out_valid && busy) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL abort_reach: got no WAIT at addr 4 want reached"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || ram_addr !== '0 || ram_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy %b valid %b addr %0d rden %b want 0 0 0 0", busy, out_valid, ram_addr, ram_rden);
    end
    for (int c = 0; c < 30; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || ram_rden !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: got busy %b rden %b want 0 0", busy, ram_rden); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ready_idle: got busy %b valid %b want 0 0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    int k = 0, rd_cnt = 0, done_cnt = 0, done_cyc = -1, bit_err = 0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_rden) rd_cnt++;
      if (out_valid && out_ready) begin
        if (k >= DEPTH || out_bit !== mem[k]) bit_err++;
        k++;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      start = (c == 4 || c == 9 || c == 14 || c == 20 || c == 25);
    end
    start = 1'b0;
    n_checks++; if (bit_err != 0 || k != DEPTH) begin n_fail++; $display("FAIL b2b_bits: got %0d bits with %0d errors want %0d bits 0 errors", k, bit_err, DEPTH); end
    n_checks++; if (rd_cnt != DEPTH) begin n_fail++; $display("FAIL b2b_reads: got %0d want %0d", rd_cnt, DEPTH); end
    n_checks++; if (done_cnt != 1 || done_cyc != 25) begin n_fail++; $display("FAIL b2b_done: got %0d pulses at cycle %0d want 1 at 25", done_cnt, done_cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_in_hold();
    bit found = 0;
    int done_cnt = 0, done_cyc = -1;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) @(negedge clk);
      if (ram_addr == 2 && !ram_rden && !out_valid && busy) found = 1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (!found || out_valid !== 1'b1 || out_bit !== mem[2]) begin n_fail++; $display("FAIL rst_hold_reach: got found %0d valid %b bit %b want 1 1 %b", found, out_valid, out_bit, mem[2]); end
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    if (done) done_cnt++;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_bit !== 1'b0 || ram_addr !== '0 || ram_rden !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold_outputs: got busy %b valid %b bit %b addr %0d rden %b done %b want all 0", busy, out_valid, out_bit, ram_addr, ram_rden, done);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (ram_rden !== 1'b1 || ram_addr !== '0) begin n_fail++; $display("FAIL rst_restart_addr: got rden %b addr %0d want 1 0", ram_rden, ram_addr); end
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) begin
        n_checks++; if (out_valid !== 1'b1 || out_bit !== mem[0]) begin n_fail++; $display("FAIL rst_restart_bit: got valid %b bit %b want 1 %b", out_valid, out_bit, mem[0]); end
      end
      if (done) begin done_cnt++; done_cyc = c; end
    end
    n_checks++; if (done_cnt != 1 || done_cyc != 25) begin n_fail++; $display("FAIL rst_restart_done: got %0d pulses at cycle %0d want 1 at 25", done_cnt, done_cyc); end
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'b10110010;
    for (int i = 0; i < DEPTH; i++) mem[i] = pat[7-i];
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    test_reset();
    test_full_pass();
    test_stall();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
